id_stage: RTL and testbench

- Instruction-decode pipeline stage of the RV32I core.
- Sits between instruction fetch and execute.
- Accepts fetched instructions over a valid/ready handshake and drives the register-file read addresses.
- Forwards in-flight results and detects load-use hazards, then launches a decoded ID/EX pipeline register into execute.

---
 rtl/id_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes the fetched word, resolves operands
// through the EX/MEM/WB forwarding network, and launches the ID/EX register.
module id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            ex_ready,
    input  logic [XLEN-1:0] ex_result,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd_addr,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [XLEN-1:0] idex_rs1_val,
    output logic [XLEN-1:0] idex_rs2_val,
    output logic [XLEN-1:0] idex_imm,
    output logic [4:0]      idex_rd_addr,
    output logic [6:0]      idex_opcode,
    output logic [2:0]      idex_funct3,
    output logic            idex_funct7b5,
    output logic            idex_reg_write,
    output logic            idex_mem_read,
    output logic            idex_mem_write,
    output logic            idex_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // Priority: x0, then youngest in-flight writer, then register file.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] rf_val,
        input logic            ex_fwd,
        input logic [4:0]      ex_rd,
        input logic [XLEN-1:0] ex_val,
        input logic            mem_fwd,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_val,
        input logic            wb_fwd,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] res;
        if (addr == 5'd0) begin
            res = '0;
        end else if (ex_fwd && (ex_rd == addr)) begin
            res = ex_val;
        end else if (mem_fwd && (mem_rd == addr)) begin
            res = mem_val;
        end else if (wb_fwd && (wb_rd == addr)) begin
            res = wb_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    logic [6:0]      opcode_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] imm_s;
    logic            reg_write_s, mem_read_s, mem_write_s, illegal_s;
    logic            rs1_used_s, rs2_used_s;
    logic            ex_fwd_s, hazard_s, advance_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;

    logic            idex_valid_r;
    logic [XLEN-1:0] idex_pc_r, idex_rs1_val_r, idex_rs2_val_r, idex_imm_r;
    logic [4:0]      idex_rd_addr_r;
    logic [6:0]      idex_opcode_r;
    logic [2:0]      idex_funct3_r;
    logic            idex_funct7b5_r, idex_reg_write_r, idex_mem_read_r;
    logic            idex_mem_write_r, idex_illegal_r;

    assign opcode_s = if_instr[6:0];
    assign rd_s     = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // Immediate selection and control decode from the opcode.
    always_comb begin
        imm_s       = '0;
        reg_write_s = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        rs1_used_s  = 1'b1;
        rs2_used_s  = 1'b0;
        case (opcode_s)
            OP_LUI, OP_AUIPC: begin
                imm_s       = {if_instr[31:12], 12'h000};
                reg_write_s = 1'b1;
                rs1_used_s  = 1'b0;
            end
            OP_JAL: begin
                imm_s       = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20],
                               if_instr[30:21], 1'b0};
                reg_write_s = 1'b1;
                rs1_used_s  = 1'b0;
            end
            OP_JALR, OP_IMM: begin
                imm_s       = {{20{if_instr[31]}}, if_instr[31:20]};
                reg_write_s = 1'b1;
            end
            OP_LOAD: begin
                imm_s       = {{20{if_instr[31]}}, if_instr[31:20]};
                reg_write_s = 1'b1;
                mem_read_s  = 1'b1;
            end
            OP_STORE: begin
                imm_s       = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                mem_write_s = 1'b1;
                rs2_used_s  = 1'b1;
            end
            OP_BRANCH: begin
                imm_s       = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25],
                               if_instr[11:8], 1'b0};
                rs2_used_s  = 1'b1;
            end
            OP_OP: begin
                reg_write_s = 1'b1;
                rs2_used_s  = 1'b1;
            end
            default: begin
                illegal_s   = 1'b1;
            end
        endcase
        if (rd_s == 5'd0) begin
            reg_write_s = 1'b0;
        end else begin
            reg_write_s = reg_write_s;
        end
    end

    // A load in ID/EX has no result yet, so it never forwards from EX.
    assign ex_fwd_s = idex_valid_r && idex_reg_write_r && !idex_mem_read_r;

    assign rs1_val_s = resolve_operand(rs1_addr, rs1_data, ex_fwd_s, idex_rd_addr_r, ex_result,
                                       mem_reg_write, mem_rd_addr, mem_result,
                                       wb_reg_write, wb_rd_addr, wb_data);
    assign rs2_val_s = resolve_operand(rs2_addr, rs2_data, ex_fwd_s, idex_rd_addr_r, ex_result,
                                       mem_reg_write, mem_rd_addr, mem_result,
                                       wb_reg_write, wb_rd_addr, wb_data);

    assign hazard_s  = if_valid && idex_valid_r && idex_mem_read_r && (idex_rd_addr_r != 5'd0) &&
                       ((rs1_used_s && (rs1_addr == idex_rd_addr_r)) ||
                        (rs2_used_s && (rs2_addr == idex_rd_addr_r)));
    assign advance_s = !idex_valid_r || ex_ready;
    assign id_ready  = flush || (advance_s && !hazard_s);

    // ID/EX register: flush, then load-use bubble, then advance, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_r     <= 1'b0;
            idex_pc_r        <= RESET_PC;
            idex_rs1_val_r   <= '0;
            idex_rs2_val_r   <= '0;
            idex_imm_r       <= '0;
            idex_rd_addr_r   <= 5'd0;
            idex_opcode_r    <= 7'd0;
            idex_funct3_r    <= 3'd0;
            idex_funct7b5_r  <= 1'b0;
            idex_reg_write_r <= 1'b0;
            idex_mem_read_r  <= 1'b0;
            idex_mem_write_r <= 1'b0;
            idex_illegal_r   <= 1'b0;
        end else if (flush) begin
            idex_valid_r     <= 1'b0;
        end else if (advance_s && hazard_s) begin
            idex_valid_r     <= 1'b0;
        end else if (advance_s) begin
            idex_valid_r     <= if_valid;
            idex_pc_r        <= if_pc;
            idex_rs1_val_r   <= rs1_val_s;
            idex_rs2_val_r   <= rs2_val_s;
            idex_imm_r       <= imm_s;
            idex_rd_addr_r   <= rd_s;
            idex_opcode_r    <= opcode_s;
            idex_funct3_r    <= if_instr[14:12];
            idex_funct7b5_r  <= if_instr[30];
            idex_reg_write_r <= reg_write_s;
            idex_mem_read_r  <= mem_read_s;
            idex_mem_write_r <= mem_write_s;
            idex_illegal_r   <= illegal_s;
        end
    end

    assign idex_valid     = idex_valid_r;
    assign idex_pc        = idex_pc_r;
    assign idex_rs1_val   = idex_rs1_val_r;
    assign idex_rs2_val   = idex_rs2_val_r;
    assign idex_imm       = idex_imm_r;
    assign idex_rd_addr   = idex_rd_addr_r;
    assign idex_opcode    = idex_opcode_r;
    assign idex_funct3    = idex_funct3_r;
    assign idex_funct7b5  = idex_funct7b5_r;
    assign idex_reg_write = idex_reg_write_r;
    assign idex_mem_read  = idex_mem_read_r;
    assign idex_mem_write = idex_mem_write_r;
    assign idex_illegal   = idex_illegal_r;

endmodule

// File: tb/tb_id_stage.sv
// Testbench for id_stage: directed scenarios plus randomized traffic checked
// against a rule-level model of decode, forwarding, hazards and the ID/EX register.
module tb_id_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
    } idex_t;

    localparam idex_t RST_EXP = '{valid: 1'b0, pc: RST_PC, default: '0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
    logic [31:0] if_instr = 32'd0, if_pc = 32'd0, ex_result = 32'd0;
    logic        mem_reg_write = 1'b0, wb_reg_write = 1'b0;
    logic [4:0]  mem_rd_addr = 5'd0, wb_rd_addr = 5'd0;
    logic [31:0] mem_result = 32'd0, wb_data = 32'd0;
    logic        id_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        idex_valid, idex_funct7b5, idex_reg_write, idex_mem_read, idex_mem_write, idex_illegal;
    logic [31:0] idex_pc, idex_rs1_val, idex_rs2_val, idex_imm;
    logic [4:0]  idex_rd_addr;
    logic [6:0]  idex_opcode;
    logic [2:0]  idex_funct3;

    logic [31:0] rf [32];
    idex_t       m;
    idex_t       dut_v;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];
    assign dut_v = {idex_valid, idex_pc, idex_rs1_val, idex_rs2_val, idex_imm, idex_rd_addr,
                    idex_opcode, idex_funct3, idex_funct7b5, idex_reg_write, idex_mem_read,
                    idex_mem_write, idex_illegal};

    id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .id_ready(id_ready), .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_ready(ex_ready), .ex_result(ex_result),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .idex_valid(idex_valid), .idex_pc(idex_pc), .idex_rs1_val(idex_rs1_val),
        .idex_rs2_val(idex_rs2_val), .idex_imm(idex_imm), .idex_rd_addr(idex_rd_addr),
        .idex_opcode(idex_opcode), .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_illegal(idex_illegal)
    );

    // ---------------- reference model ----------------
    function automatic idex_t ref_decode(input logic [31:0] ins);
        idex_t d;
        logic [31:0] sign;
        logic [6:0]  op;
        sign = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        op = ins[6:0];
        d = '0;
        d.op = op; d.rd = ins[11:7]; d.f3 = ins[14:12]; d.f7 = ins[30];
        case (op)
            7'b0110111, 7'b0010111: begin d.imm = ins & 32'hFFFF_F000; d.rw = 1'b1; end
            7'b1101111: begin
                d.imm = (sign << 20) | (((ins >> 12) & 32'hFF) << 12) | (((ins >> 20) & 32'h1) << 11)
                        | (((ins >> 21) & 32'h3FF) << 1);
                d.rw = 1'b1;
            end
            7'b1100111, 7'b0010011: begin d.imm = (sign << 12) | (ins >> 20); d.rw = 1'b1; end
            7'b0000011: begin d.imm = (sign << 12) | (ins >> 20); d.rw = 1'b1; d.mr = 1'b1; end
            7'b0100011: begin d.imm = (sign << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F); d.mw = 1'b1; end
            7'b1100011: d.imm = (sign << 12) | (((ins >> 7) & 32'h1) << 11) | (((ins >> 25) & 32'h3F) << 5)
                                | (((ins >> 8) & 32'hF) << 1);
            7'b0110011: d.rw = 1'b1;
            default: d.ill = 1'b1;
        endcase
        if (d.rd == 5'd0) d.rw = 1'b0;
        return d;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    endfunction

    function automatic logic [31:0] ref_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m.valid && m.rw && !m.mr && m.rd == a) return ex_result;
        if (mem_reg_write && mem_rd_addr == a) return mem_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_data;
        return rf[a];
    endfunction

    function automatic logic ref_hazard();
        logic [4:0] a1, a2;
        a1 = if_instr[19:15];
        a2 = if_instr[24:20];
        if (!(if_valid && m.valid && m.mr && m.rd != 5'd0)) return 1'b0;
        return (uses_rs1(if_instr[6:0]) && a1 == m.rd) || (uses_rs2(if_instr[6:0]) && a2 == m.rd);
    endfunction

    function automatic logic ref_ready();
        return flush || ((!m.valid || ex_ready) && !ref_hazard());
    endfunction

    function automatic idex_t ref_next();
        idex_t n;
        n = m;
        if (flush || ((!m.valid || ex_ready) && ref_hazard())) begin
            n.valid = 1'b0;
        end else if (!m.valid || ex_ready) begin
            n = ref_decode(if_instr);
            n.valid = if_valid;
            n.pc = if_pc;
            n.rs1v = ref_operand(if_instr[19:15]);
            n.rs2v = ref_operand(if_instr[24:20]);
        end
        return n;
    endfunction

    task automatic tick();
        idex_t n;
        n = ref_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic idle();
        if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_rd_addr = 5'd0; wb_rd_addr = 5'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++;
        if (dut_v !== RST_EXP) begin
            failures++; $display("FAIL reset_state: got %h expected %h", dut_v, RST_EXP);
        end
        m = RST_EXP;
        #1 rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_reset_midstream();
        if_valid = 1'b1; if_instr = 32'hFFD00293; if_pc = 32'h0000_0010; ex_ready = 1'b1;
        tick();
        checks++;
        if (idex_valid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_valid: got %b expected 1", idex_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (idex_valid !== 1'b0 || idex_pc !== RST_PC) begin
            failures++; $display("FAIL async_reset: valid=%b pc=%h expected valid=0 pc=%h", idex_valid, idex_pc, RST_PC);
        end
        m = RST_EXP;
        #1 rst_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_addi();
        if_valid = 1'b1; if_instr = 32'hFFD00293; if_pc = 32'h0000_0040; ex_ready = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            failures++; $display("FAIL addi_ready: got %b expected 1", id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b1 || idex_imm !== 32'hFFFF_FFFD || idex_rd_addr !== 5'd5 ||
            idex_reg_write !== 1'b1 || idex_rs1_val !== 32'd0 || idex_pc !== 32'h40) begin
            failures++;
            $display("FAIL addi_fields: valid=%b imm=%h rd=%0d rw=%b rs1=%h pc=%h expected 1 fffffffd 5 1 0 40",
                     idex_valid, idex_imm, idex_rd_addr, idex_reg_write, idex_rs1_val, idex_pc);
        end
        checks++;
        if (dut_v !== m) begin
            failures++; $display("FAIL addi_model: got %h expected %h", dut_v, m);
        end
    endtask

    task automatic test_ex_forward();
        rf[1] = 32'h0101_0101; rf[2] = 32'h0202_0202; rf[3] = 32'h0303_0303;
        if_valid = 1'b1; if_instr = 32'h002081B3; if_pc = 32'h44; ex_result = 32'h9999;
        tick();
        checks++;
        if (idex_rs1_val !== 32'h0101_0101 || idex_rs2_val !== 32'h0202_0202 || dut_v !== m) begin
            failures++; $display("FAIL add_operands: got %h expected %h", dut_v, m);
        end
        if_instr = 32'h40118233; if_pc = 32'h48; ex_result = 32'h77;
        mem_reg_write = 1'b1; mem_rd_addr = 5'd3; mem_result = 32'h11;
        tick();
        checks++;
        if (idex_rs1_val !== 32'h77 || idex_rs2_val !== 32'h0101_0101 || idex_funct7b5 !== 1'b1) begin
            failures++; $display("FAIL ex_forward: rs1=%h rs2=%h f7b5=%b expected 77 01010101 1",
                                 idex_rs1_val, idex_rs2_val, idex_funct7b5);
        end
        checks++;
        if (dut_v !== m) begin
            failures++; $display("FAIL ex_forward_model: got %h expected %h", dut_v, m);
        end
        mem_reg_write = 1'b0;
    endtask

    task automatic test_load_use();
        if_valid = 1'b1; if_instr = 32'h0000A303; if_pc = 32'h4C; ex_result = 32'h77;
        tick();
        checks++;
        if (idex_mem_read !== 1'b1 || idex_rd_addr !== 5'd6 || dut_v !== m) begin
            failures++; $display("FAIL lw_launch: got %h expected %h", dut_v, m);
        end
        if_instr = 32'h006303B3; if_pc = 32'h50; ex_result = 32'h5555;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin
            failures++; $display("FAIL load_use_ready: got %b expected 0", id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b0) begin
            failures++; $display("FAIL load_use_bubble: got %b expected 0", idex_valid);
        end
        mem_reg_write = 1'b1; mem_rd_addr = 5'd6; mem_result = 32'hCAFE;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            failures++; $display("FAIL load_use_release: got %b expected 1", id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b1 || idex_rs1_val !== 32'hCAFE || idex_rs2_val !== 32'hCAFE || idex_rd_addr !== 5'd7) begin
            failures++; $display("FAIL load_use_forward: valid=%b rs1=%h rs2=%h rd=%0d expected 1 cafe cafe 7",
                                 idex_valid, idex_rs1_val, idex_rs2_val, idex_rd_addr);
        end
        mem_reg_write = 1'b0;
    endtask

    task automatic test_wb_forward();
        rf[9] = 32'd0;
        wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_data = 32'h1234;
        if_valid = 1'b1; if_instr = 32'h00048513; if_pc = 32'h54;
        tick();
        checks++;
        if (idex_rs1_val !== 32'h1234 || dut_v !== m) begin
            failures++; $display("FAIL wb_forward: rs1=%h expected 1234", idex_rs1_val);
        end
        wb_rd_addr = 5'd0; wb_data = 32'hDEAD;
        if_instr = 32'h00500593; if_pc = 32'h58;
        tick();
        checks++;
        if (idex_rs1_val !== 32'd0 || idex_imm !== 32'd5) begin
            failures++; $display("FAIL wb_x0: rs1=%h imm=%h expected 0 5", idex_rs1_val, idex_imm);
        end
        wb_reg_write = 1'b0;
    endtask

    task automatic test_stall_flush();
        idex_t snap;
        if_valid = 1'b1; if_instr = 32'h0FF0E693; if_pc = 32'h5C; ex_ready = 1'b1;
        tick();
        snap = m;
        checks++;
        if (snap.valid !== 1'b1 || dut_v !== snap) begin
            failures++; $display("FAIL stall_setup: got %h expected %h", dut_v, snap);
        end
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if_instr = 32'h00B50633 + 32'(i); if_pc = 32'h60 + 32'(4 * i);
            ex_result = $urandom; mem_reg_write = 1'b1; mem_rd_addr = 5'd1; mem_result = $urandom;
            #1;
            checks++;
            if (id_ready !== 1'b0) begin
                failures++; $display("FAIL stall_ready: cycle %0d got %b expected 0", i, id_ready);
            end
            tick();
            checks++;
            if (dut_v !== snap) begin
                failures++; $display("FAIL stall_hold: cycle %0d got %h expected %h", i, dut_v, snap);
            end
        end
        flush = 1'b1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            failures++; $display("FAIL flush_ready: got %b expected 1", id_ready);
        end
        tick();
        checks++;
        if (idex_valid !== 1'b0 || dut_v !== m) begin
            failures++; $display("FAIL flush_kill: got %h expected %h", dut_v, m);
        end
        idle();
    endtask

    task automatic test_illegal();
        if_valid = 1'b1; if_instr = 32'h0000_0FFF; if_pc = 32'h80; ex_ready = 1'b1;
        tick();
        checks++;
        if (idex_valid !== 1'b1 || idex_illegal !== 1'b1 || idex_reg_write !== 1'b0 ||
            idex_mem_read !== 1'b0 || idex_mem_write !== 1'b0) begin
            failures++; $display("FAIL illegal: valid=%b ill=%b rw=%b mr=%b mw=%b expected 1 1 0 0 0",
                                 idex_valid, idex_illegal, idex_reg_write, idex_mem_read, idex_mem_write);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [10];
        logic [31:0] ins;
        ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1010111};
        for (int r = 1; r < 32; r++) rf[r] = $urandom;
        for (int c = 0; c < 600; c++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            ins[11:7] = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if_instr = ins; if_pc = $urandom;
            if_valid = ($urandom_range(0, 9) < 8);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 9) == 0);
            ex_result = $urandom; mem_result = $urandom; wb_data = $urandom;
            mem_reg_write = $urandom_range(0, 1); mem_rd_addr = 5'($urandom_range(0, 3));
            wb_reg_write = $urandom_range(0, 1); wb_rd_addr = 5'($urandom_range(0, 3));
            #1;
            checks++;
            if (id_ready !== ref_ready()) begin
                failures++; $display("FAIL rand_ready: cycle %0d got %b expected %b", c, id_ready, ref_ready());
            end
            tick();
            checks++;
            if (dut_v !== m) begin
                failures++; $display("FAIL rand_idex: cycle %0d got %h expected %h", c, dut_v, m);
            end
        end
        idle();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : 32'h1000_0000 + 32'(r);
        m = RST_EXP;
        test_reset();
        test_reset_midstream();
        test_addi();
        test_ex_forward();
        test_load_use();
        test_wb_forward();
        test_stall_flush();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
